// File: rtl/pdm_cic_receiver.sv
// PDM microphone receiver: generates the mic clock, samples the bitstream and
// decimates it through a third-order CIC filter into a valid/ready PCM stream.
module pdm_cic_receiver #(
  parameter int PDM_COUNT_PERIOD = 32,
  parameter int DEC_LOG2         = 6,
  parameter int DISCARD          = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               mic_data_in,
  output logic               mic_clk_out,
  output logic               pdm_valid_out,
  output logic signed [15:0] sample_out,
  output logic               sample_valid_out,
  input  logic               sample_ready_in,
  output logic               overrun_out
);

  localparam int CNT_W  = $clog2(PDM_COUNT_PERIOD);
  localparam int ACC_W  = 2 + 3 * DEC_LOG2;
  localparam int SHIFT  = 3 * DEC_LOG2 - 15;
  localparam int DISC_W = $clog2(DISCARD + 2);

  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(PDM_COUNT_PERIOD - 1);
  localparam logic [CNT_W-1:0]        CNT_HALF  = CNT_W'(PDM_COUNT_PERIOD / 2);
  localparam logic [DEC_LOG2-1:0]     TICK_LAST = {DEC_LOG2{1'b1}};
  localparam logic [DISC_W-1:0]       DISC_DONE = DISC_W'(DISCARD);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-32768);

  // Arithmetic shift down to 16 bits, clamping instead of wrapping.
  function automatic logic signed [15:0] scale_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> SHIFT;
    if (sh > SAT_MAX) begin
      scale_sat = 16'sh7fff;
    end else if (sh < SAT_MIN) begin
      scale_sat = 16'sh8000;
    end else begin
      scale_sat = sh[15:0];
    end
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mic_clk_q, mic_clk_d, mic_dly_q, tick_q, tick_d;
  logic [DEC_LOG2-1:0]     win_q, win_d;
  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic                    comb_go_q, comb_go_d;
  logic [DISC_W-1:0]       disc_q, disc_d;
  logic signed [15:0]      sample_q, sample_d;
  logic                    valid_q, valid_d, ovr_q, ovr_d;
  logic signed [ACC_W-1:0] x_s, c1_s, c2_s, c3_s;
  logic signed [15:0]      res_s;
  logic                    load_s;

  // Mic clock divider and tick pulse generation.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    mic_clk_d = (cnt_q < CNT_HALF);
    tick_d    = mic_clk_q & ~mic_dly_q;
  end

  // Integrators advance on ticks; combs run once the cycle after a window closes.
  always_comb begin
    x_s       = mic_data_in ? ACC_W'(1) : ACC_W'(-1);
    c1_s      = i3_q - d1_q;
    c2_s      = c1_s - d2_q;
    c3_s      = c2_s - d3_q;
    res_s     = scale_sat(c3_s);
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    win_d     = win_q;
    comb_go_d = 1'b0;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    disc_d    = disc_q;
    if (tick_q) begin
      i1_d      = i1_q + x_s;
      i2_d      = i2_q + i1_q;
      i3_d      = i3_q + i2_q;
      win_d     = win_q + DEC_LOG2'(1);
      comb_go_d = (win_q == TICK_LAST);
    end else begin
      comb_go_d = 1'b0;
    end
    if (comb_go_q) begin
      d1_d = i3_q;
      d2_d = c1_s;
      d3_d = c2_s;
      if (disc_q == DISC_DONE) begin
        disc_d = disc_q;
      end else begin
        disc_d = disc_q + DISC_W'(1);
      end
    end else begin
      disc_d = disc_q;
    end
  end

  // Output holding register: a fresh result always wins over a pending one.
  always_comb begin
    load_s   = comb_go_q & (disc_q == DISC_DONE);
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (load_s) begin
      sample_d = res_s;
      valid_d  = 1'b1;
      if (valid_q & ~sample_ready_in) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (valid_q & sample_ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q     <= '0;
      mic_clk_q <= 1'b0;
      mic_dly_q <= 1'b0;
      tick_q    <= 1'b0;
      win_q     <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      comb_go_q <= 1'b0;
      disc_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mic_clk_q <= mic_clk_d;
      mic_dly_q <= mic_clk_q;
      tick_q    <= tick_d;
      win_q     <= win_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      comb_go_q <= comb_go_d;
      disc_q    <= disc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mic_clk_out      = mic_clk_q;
  assign pdm_valid_out    = tick_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = ovr_q;

endmodule
